// File: rtl/prince_cms_cubic_term.sv
// prince_cms_cubic_term: masked (CMS) evaluator for the cubic monomial y&z&w.
// Expands SHARES shares of y, z, w into all SHARES^3 cross products, registers
// them behind a glitch barrier (S1) and, when COMPRESS=1, ring-refreshes them
// and XOR-compresses back to SHARES shares in a second register stage (S2).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (transfer on in_valid && in_ready)
//   y_sh, z_sh, w_sh    input shares, lane l share i at bit l*SHARES+i
//   rnd                 refresh randomness, lane l bit p at l*NPROD+p
//   out_valid/out_ready output handshake
//   out_sh              output shares, lane l share s at bit l*OSH+s
module prince_cms_cubic_term #(
    parameter int unsigned SHARES   = 2,
    parameter int unsigned LANES    = 1,
    parameter int unsigned COMPRESS = 0,
    localparam int unsigned NPROD   = SHARES * SHARES * SHARES,
    localparam int unsigned OSH     = (COMPRESS == 1) ? SHARES : NPROD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*SHARES-1:0]  y_sh,
    input  logic [LANES*SHARES-1:0]  z_sh,
    input  logic [LANES*SHARES-1:0]  w_sh,
    input  logic [LANES*NPROD-1:0]   rnd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*OSH-1:0]     out_sh
);

    if (SHARES < 2 || LANES < 1 || COMPRESS > 1) begin : g_bad_params
        $error("prince_cms_cubic_term: need SHARES>=2, LANES>=1, COMPRESS in {0,1}");
    end

    logic [LANES*NPROD-1:0] prod;
    logic [LANES*NPROD-1:0] s1_d;
    logic [LANES*NPROD-1:0] s1_q;
    logic                   s1_v;
    logic                   adv1;

    // Cross products, index p = i*SHARES^2 + j*SHARES + k; never XORed together here.
    always_comb begin
        prod = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            for (int unsigned i = 0; i < SHARES; i++) begin
                for (int unsigned j = 0; j < SHARES; j++) begin
                    for (int unsigned k = 0; k < SHARES; k++) begin
                        prod[l*NPROD + i*SHARES*SHARES + j*SHARES + k] =
                            y_sh[l*SHARES + i] & z_sh[l*SHARES + j] & w_sh[l*SHARES + k];
                    end
                end
            end
        end
    end

    // Stage 1 register: the glitch barrier between product terms and any XOR.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
            s1_q <= '0;
        end else if (adv1) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    assign in_ready = adv1;

    if (COMPRESS == 0) begin : g_expand
        // rnd has no role without compression.
        logic unused_rnd;
        assign unused_rnd = ^rnd;

        assign s1_d      = prod;
        assign adv1      = !s1_v || out_ready;
        assign out_valid = s1_v;
        assign out_sh    = s1_q;
    end else begin : g_compress
        logic [LANES*SHARES-1:0] s2_d;
        logic [LANES*SHARES-1:0] s2_q;
        logic                    s2_v;
        logic                    adv2;

        // Ring refresh: each rnd bit enters two neighbouring products and cancels in the sum.
        always_comb begin
            s1_d = prod;
            for (int unsigned l = 0; l < LANES; l++) begin
                for (int unsigned p = 0; p < NPROD; p++) begin
                    s1_d[l*NPROD + p] = prod[l*NPROD + p] ^ rnd[l*NPROD + p]
                                      ^ rnd[l*NPROD + ((p + 1) % NPROD)];
                end
            end
        end

        // Compression: output share g collects every product with p mod SHARES == g.
        always_comb begin
            s2_d = '0;
            for (int unsigned l = 0; l < LANES; l++) begin
                for (int unsigned p = 0; p < NPROD; p++) begin
                    s2_d[l*SHARES + (p % SHARES)] ^= s1_q[l*NPROD + p];
                end
            end
        end

        assign adv2 = !s2_v || out_ready;
        assign adv1 = !s1_v || adv2;

        always_ff @(posedge clk) begin
            if (rst) begin
                s2_v <= 1'b0;
                s2_q <= '0;
            end else if (adv2) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_q <= s2_d;
                end
            end
        end

        assign out_valid = s2_v;
        assign out_sh    = s2_q;
    end

endmodule
